// File: rtl/uart_buffer_ctrl_if.sv
// uart_buffer_ctrl_if: push/pop valid-ready handshake between UART logic and the byte buffer
interface uart_buffer_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             push_valid;
  logic [WIDTH-1:0] push_data;
  logic             push_ready;
  logic             pop_valid;
  logic [WIDTH-1:0] pop_data;
  logic             pop_ready;
  modport master (output push_valid, push_data, pop_ready, input push_ready, pop_valid, pop_data);
  modport slave  (input push_valid, push_data, pop_ready, output push_ready, pop_valid, pop_data);
endinterface

// File: rtl/uart_buffer_ctrl.sv
// uart_buffer_ctrl: FIFO controller sequencing a 1-cycle sync-read RAM as the UART byte buffer
module uart_buffer_ctrl #(
  parameter int WIDTH_MEM = 8,
  parameter int DEPTH_MEM = 16,
  localparam int AW = $clog2(DEPTH_MEM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  uart_buffer_ctrl_if.slave    bus,
  output logic [AW:0]          occupancy,
  output logic                 overflow,
  output logic                 ram_wr_en,
  output logic [AW-1:0]        ram_wr_addr,
  output logic [WIDTH_MEM-1:0] ram_wr_data,
  output logic                 ram_rd_en,
  output logic [AW-1:0]        ram_rd_addr,
  input  logic [WIDTH_MEM-1:0] ram_rd_data
);
  typedef enum logic {EMPTY, VALID} state_t;
  state_t         state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    occ_q, occ_d;
  logic           ovf_q, ovf_d, not_full, wr_en, rd_en;
  // Decode RAM accesses from registered state and compute next state; flush overrides everything
  always_comb begin
    not_full = occ_q != (AW+1)'(DEPTH_MEM);
    wr_en    = bus.push_valid & not_full & ~flush & ~rst;
    rd_en    = (occ_q != '0) & (state_q == EMPTY | bus.pop_ready) & ~flush & ~rst;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(wr_en);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(rd_en);
    occ_d    = flush ? '0 : occ_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    ovf_d    = ~flush & (ovf_q | (bus.push_valid & ~not_full));
    state_d  = flush ? EMPTY : (rd_en | (state_q == VALID & ~bus.pop_ready)) ? VALID : EMPTY;
  end
  // Pointers, occupancy, sticky overflow and output-stage state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
    end
  end
  assign bus.push_ready = not_full;
  assign bus.pop_valid  = state_q == VALID;
  assign bus.pop_data   = state_q == VALID ? ram_rd_data : '0;
  assign occupancy      = occ_q;
  assign overflow       = ovf_q;
  assign ram_wr_en      = wr_en;
  assign ram_wr_addr    = wr_ptr_q;
  assign ram_wr_data    = bus.push_data;
  assign ram_rd_en      = rd_en;
  assign ram_rd_addr    = rd_ptr_q;
endmodule
